// File: rtl/event_byte_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : event_byte_serializer_if
// Description : Bundles the event input handshake and the byte output bus of
//               event_byte_serializer.
//               slave  - the serializer side (takes events, drives bytes)
//               master - the environment side (drives events, takes bytes)
// Ports       : in_x/in_y/in_t/in_p/in_valid -> event payload and valid
//               in_ready                      <- FIFO has room
//               dout/dout_valid/dout_sof      <- output byte stream
//               dout_ready                    -> downstream accepts byte
//               fifo_level                    <- events held, incl. in flight
// Revision    : 1.0 - initial release
// ============================================================================
interface event_byte_serializer_if;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [15:0] in_t;
  logic        in_p;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_sof;
  logic [4:0]  fifo_level;

  modport master (
    output in_x, in_y, in_t, in_p, in_valid, dout_ready,
    input  in_ready, dout, dout_valid, dout_sof, fifo_level
  );

  modport slave (
    input  in_x, in_y, in_t, in_p, in_valid, dout_ready,
    output in_ready, dout, dout_valid, dout_sof, fifo_level
  );
endinterface
`default_nettype wire

// File: rtl/event_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : event_byte_serializer
// Description : Buffers DVS events (x, y, t, p) in a DEPTH-entry FIFO and sends
//               each one as a 7-byte frame on a registered 8-bit valid/ready
//               bus: {SYNC,6'b0,p}, x hi, x lo, y hi, y lo, t hi, t lo.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - event_byte_serializer_if.slave (event in, bytes out,
//                       fifo_level)
// Parameters  : DEPTH - FIFO entries, power of two, 2..16
//               SYNC  - value of header bit 7
// Revision    : 1.0 - initial release
// ============================================================================
module event_byte_serializer #(
  parameter int DEPTH = 4,
  parameter int SYNC  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  event_byte_serializer_if.slave        bus
);

  localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] c_depth    = 5'(DEPTH);
  localparam logic       c_sync_bit = (SYNC != 0);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_send = 1'b1;

  // Entry layout: {p, x, y, t}
  logic [48:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]    r_level;
  logic [0:0]    r_state;
  logic [2:0]    r_idx;
  logic [7:0]    r_dout;
  logic          r_dout_valid;
  logic          r_dout_sof;

  logic          w_in_ready;
  logic          w_push;
  logic          w_accept;
  logic          w_pop;
  logic [48:0]   w_head;
  logic [48:0]   w_next;

  function automatic logic [7:0] frame_byte(input logic [48:0] e, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {c_sync_bit, 6'b0, e[48]};
      3'd1:    b = e[47:40];
      3'd2:    b = e[39:32];
      3'd3:    b = e[31:24];
      3'd4:    b = e[23:16];
      3'd5:    b = e[15:8];
      3'd6:    b = e[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Ready comes only from the registered level, so a pop in the same cycle
  // never opens a slot for a push while full.
  assign w_in_ready = (r_level != c_depth);
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_accept   = r_dout_valid && bus.dout_ready;
  assign w_pop      = w_accept && (r_idx == 3'd6);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_next     = r_mem[r_rd_ptr + AW'(1)];

  assign bus.in_ready   = w_in_ready;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout_sof   = r_dout_sof;
  assign bus.fifo_level = r_level;

  // Storage is not reset: contents are only observable through valid entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_p, bus.in_x, bus.in_y, bus.in_t};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= 5'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_idle;
      r_idx        <= 3'd0;
      r_dout       <= 8'h00;
      r_dout_valid <= 1'b0;
      r_dout_sof   <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (r_level != 5'd0) begin
            r_state      <= c_send;
            r_idx        <= 3'd0;
            r_dout       <= frame_byte(w_head, 3'd0);
            r_dout_valid <= 1'b1;
            r_dout_sof   <= 1'b1;
          end
        end
        c_send: begin
          if (w_accept) begin
            if (r_idx != 3'd6) begin
              r_idx      <= r_idx + 3'd1;
              r_dout     <= frame_byte(w_head, r_idx + 3'd1);
              r_dout_sof <= 1'b0;
            end else if (r_level > 5'd1) begin
              // Another stored entry sits behind the head: start its header
              // on the very next cycle so frames stay back-to-back.
              r_idx      <= 3'd0;
              r_dout     <= frame_byte(w_next, 3'd0);
              r_dout_sof <= 1'b1;
            end else begin
              r_state      <= c_idle;
              r_idx        <= 3'd0;
              r_dout       <= 8'h00;
              r_dout_valid <= 1'b0;
              r_dout_sof   <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= c_idle;
          r_idx        <= 3'd0;
          r_dout_valid <= 1'b0;
          r_dout_sof   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_event_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_byte_serializer
// Description : Scoreboard bench for event_byte_serializer (DEPTH=4, SYNC=1).
//               Stimulus pushes expected {sof, byte} pairs into a queue; a
//               monitor on the falling edge pops and compares every accepted
//               byte and checks that stalled bytes hold stable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_byte_serializer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [8:0] exp_q[$];

  event_byte_serializer_if bus();

  event_byte_serializer #(.DEPTH(4), .SYNC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor ----------------
  logic       hold_pending;
  logic [9:0] hold_val;
  initial hold_pending = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        total++;
        if ({bus.dout_valid, bus.dout_sof, bus.dout} !== hold_val) begin
          bad++;
          $display("FAIL hold: got v=%b sof=%b %h want v=%b sof=%b %h",
                   bus.dout_valid, bus.dout_sof, bus.dout,
                   hold_val[9], hold_val[8], hold_val[7:0]);
        end
      end
      hold_pending = bus.dout_valid && !bus.dout_ready;
      hold_val     = {bus.dout_valid, bus.dout_sof, bus.dout};
      if (bus.dout_valid && bus.dout_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL byte: got sof=%b %h want none", bus.dout_sof, bus.dout);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({bus.dout_sof, bus.dout} !== e) begin
            bad++;
            $display("FAIL byte: got sof=%b %h want sof=%b %h",
                     bus.dout_sof, bus.dout, e[8], e[7:0]);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] hdr(input logic p);
    return {1'b1, 6'b0, p};
  endfunction

  task automatic expect_event(input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] t, input logic p);
    exp_q.push_back({1'b1, hdr(p)});
    exp_q.push_back({1'b0, x[15:8]});
    exp_q.push_back({1'b0, x[7:0]});
    exp_q.push_back({1'b0, y[15:8]});
    exp_q.push_back({1'b0, y[7:0]});
    exp_q.push_back({1'b0, t[15:8]});
    exp_q.push_back({1'b0, t[7:0]});
  endtask

  // Returns just after the edge that takes the event.
  task automatic push_event(input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] t, input logic p);
    int n;
    bus.in_x = x; bus.in_y = y; bus.in_t = t; bus.in_p = p;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      step();
      n++;
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL push_wait: got in_ready=0 want 1");
    end else begin
      expect_event(x, y, t, p);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.dout_valid) && n < 500) begin
      step();
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", bus.dout_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int run;
    int n;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_x = '0; bus.in_y = '0; bus.in_t = '0; bus.in_p = 1'b0;
    bus.in_valid = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_dout",  bus.dout, 8'h00);
    check("rst_valid", bus.dout_valid, 0);
    check("rst_sof",   bus.dout_sof, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_level", bus.fifo_level, 0);

    // Single event, latency and byte sequence
    bus.in_x = 16'h1234; bus.in_y = 16'hABCD; bus.in_t = 16'h00FF; bus.in_p = 1'b1;
    bus.in_valid = 1'b1;
    exp_q.push_back({1'b1, 8'h81});
    exp_q.push_back({1'b0, 8'h12});
    exp_q.push_back({1'b0, 8'h34});
    exp_q.push_back({1'b0, 8'hAB});
    exp_q.push_back({1'b0, 8'hCD});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    step();
    bus.in_valid = 1'b0;
    check("lat_level", bus.fifo_level, 1);
    check("lat_valid_early", bus.dout_valid, 0);
    step();
    check("lat_valid", bus.dout_valid, 1);
    check("lat_byte0", bus.dout, 8'h81);
    check("lat_sof0", bus.dout_sof, 1);
    repeat (6) step();
    check("single_last", bus.dout, 8'hFF);
    step();
    check("single_done_valid", bus.dout_valid, 0);
    check("single_done_q", exp_q.size(), 0);

    // Backpressure during byte 3
    push_event(16'h1234, 16'hABCD, 16'h00FF, 1'b1);
    n = 0;
    while (!(bus.dout_valid && bus.dout == 8'hAB) && n < 20) begin
      step();
      n++;
    end
    check("bp_reach", bus.dout, 8'hAB);
    bus.dout_ready = 1'b0;
    step();
    step();
    check("bp_held", bus.dout, 8'hAB);
    bus.dout_ready = 1'b1;
    drain();

    // Full FIFO
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_event(16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i), 1'(i));
    check("full_level", bus.fifo_level, 4);
    check("full_ready", bus.in_ready, 0);
    fork
      push_event(16'hF00D, 16'hBEEF, 16'hCAFE, 1'b1);
      begin
        repeat (3) step();
        check("full_stall_level", bus.fifo_level, 4);
        check("full_stall_ready", bus.in_ready, 0);
        bus.dout_ready = 1'b1;
      end
    join
    drain();

    // Back-to-back frames
    push_event(16'h0102, 16'h0304, 16'h0506, 1'b0);
    push_event(16'h1112, 16'h1314, 16'h1516, 1'b1);
    push_event(16'h2122, 16'h2324, 16'h2526, 1'b0);
    run = 2;
    n = 0;
    step();
    while (bus.dout_valid && n < 40) begin
      run++;
      n++;
      step();
    end
    check("b2b_run", run, 21);
    drain();

    // Pointer wrap: 10 events in order
    for (int i = 0; i < 10; i++)
      push_event(16'hA000 + 16'(i * 3), 16'hB000 + 16'(i * 5), 16'hC000 + 16'(i * 7), 1'(i));
    drain();

    // Simultaneous push and pop at level 2
    bus.dout_ready = 1'b0;
    push_event(16'h5A5A, 16'h6B6B, 16'h7C7C, 1'b1);
    push_event(16'h0F0F, 16'h1E1E, 16'h2D2D, 1'b0);
    check("pp_level_before", bus.fifo_level, 2);
    bus.dout_ready = 1'b1;
    repeat (6) step();
    check("pp_at_byte6", bus.dout, 8'h7C);
    push_event(16'h4321, 16'h8765, 16'hCBA9, 1'b1);
    check("pp_level_after", bus.fifo_level, 2);
    drain();

    // Reset mid-frame
    push_event(16'h1111, 16'h2222, 16'h3333, 1'b1);
    push_event(16'h4444, 16'h5555, 16'h6666, 1'b0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.dout_valid, 0);
    check("midrst_ready", bus.in_ready, 1);
    check("midrst_level", bus.fifo_level, 0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    check("postrst_valid", bus.dout_valid, 0);
    check("postrst_level", bus.fifo_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
